// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encodings and helpers for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    localparam logic ARB_OWNER_IF = 1'b0;
    localparam logic ARB_OWNER_DM = 1'b1;

    // Instructions are 32 bits inside a 64-bit beat; address bit 2 picks the half.
    function automatic logic [31:0] fetch_word(input logic [63:0] beat, input logic hi);
        return hi ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rtl/mem_port_arbiter_rr_arb2.sv - two-way round-robin grant with last-grant history
module rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_if,
    input  logic req_dm,
    output logic gnt_if,
    output logic gnt_dm
);

    logic last_grant;
    logic pick_dm;

    // On a tie the requester that did not win last time takes the port.
    always_comb begin
        pick_dm = req_dm && (!req_if || (last_grant == ARB_OWNER_IF));
        gnt_dm  = en && pick_dm;
        gnt_if  = en && req_if && !pick_dm;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= ARB_OWNER_DM;
        end else if (en && (req_if || req_dm)) begin
            last_grant <= pick_dm ? ARB_OWNER_DM : ARB_OWNER_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and load/store
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_rsp_valid,
    output logic [31:0]         if_rsp_data,

    input  logic                dm_req_valid,
    output logic                dm_req_ready,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_wstrb,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_rsp_valid,
    output logic [DATA_W-1:0]   dm_rsp_data,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,

    output logic                busy
);

    arb_state_e state;
    logic       owner;
    logic       arb_en;
    logic       gnt_if;
    logic       gnt_dm;

    // Readies are held low while reset is asserted so no acceptance is ever reported that the flops ignore.
    assign arb_en       = rst && (state == ARB_IDLE);
    assign if_req_ready = gnt_if;
    assign dm_req_ready = gnt_dm;

    assign mem_req_valid = (state == ARB_ISSUE);
    assign busy          = (state != ARB_IDLE);

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .en     (arb_en),
        .req_if (if_req_valid),
        .req_dm (dm_req_valid),
        .gnt_if (gnt_if),
        .gnt_dm (gnt_dm)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ARB_IDLE;
            owner        <= ARB_OWNER_IF;
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            mem_wstrb    <= '0;
            mem_wdata    <= '0;
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            dm_rsp_valid <= 1'b0;
            dm_rsp_data  <= '0;
        end else begin
            if_rsp_valid <= 1'b0;
            dm_rsp_valid <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (gnt_dm) begin
                        mem_addr  <= dm_addr;
                        mem_we    <= dm_we;
                        mem_wstrb <= dm_wstrb;
                        mem_wdata <= dm_wdata;
                        owner     <= ARB_OWNER_DM;
                        state     <= ARB_ISSUE;
                    end else if (gnt_if) begin
                        mem_addr  <= if_addr;
                        mem_we    <= 1'b0;
                        mem_wstrb <= '0;
                        mem_wdata <= '0;
                        owner     <= ARB_OWNER_IF;
                        state     <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (mem_req_ready) begin
                        state <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (mem_rsp_valid) begin
                        if (owner == ARB_OWNER_IF) begin
                            if_rsp_valid <= 1'b1;
                            if_rsp_data  <= fetch_word(mem_rsp_data[63:0], mem_addr[2]);
                        end else begin
                            dm_rsp_valid <= 1'b1;
                            dm_rsp_data  <= mem_rsp_data;
                        end
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_valid = 1'b0;
    logic        if_req_ready;
    logic [63:0] if_addr = '0;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        dm_req_valid = 1'b0;
    logic        dm_req_ready;
    logic [63:0] dm_addr = '0;
    logic        dm_we = 1'b0;
    logic [7:0]  dm_wstrb = '0;
    logic [63:0] dm_wdata = '0;
    logic        dm_rsp_valid;
    logic [63:0] dm_rsp_data;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wstrb;
    logic [63:0] mem_wdata;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rsp_data = '0;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_addr       (if_addr),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_data   (if_rsp_data),
        .dm_req_valid  (dm_req_valid),
        .dm_req_ready  (dm_req_ready),
        .dm_addr       (dm_addr),
        .dm_we         (dm_we),
        .dm_wstrb      (dm_wstrb),
        .dm_wdata      (dm_wdata),
        .dm_rsp_valid  (dm_rsp_valid),
        .dm_rsp_data   (dm_rsp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wstrb     (mem_wstrb),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are then changed 1ns after the edge and checked 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_if_ready", if_req_ready, 0);
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rsp_valid", {if_rsp_valid, dm_rsp_valid}, 0);
        chk("rst_rsp_data", dm_rsp_data, 0);
        tick();
        rst = 1'b1;
        tick();

        // single fetch, addr[2]=1 selects upper word
        if_req_valid = 1'b1; if_addr = 64'h8000_0004; mem_req_ready = 1'b1;
        settle();
        chk("f_if_ready", if_req_ready, 1);
        chk("f_dm_ready", dm_req_ready, 0);
        tick();
        if_req_valid = 1'b0;
        settle();
        chk("f_mem_valid", mem_req_valid, 1);
        chk("f_mem_addr", mem_addr, 64'h8000_0004);
        chk("f_mem_we", {mem_we, mem_wstrb}, 0);
        chk("f_busy", busy, 1);
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'h1111_2222_3333_4444;
        settle();
        chk("f_mem_valid_wait", mem_req_valid, 0);
        chk("f_early_rsp", if_rsp_valid, 0);
        tick();
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        settle();
        chk("f_rsp_valid", if_rsp_valid, 1);
        chk("f_rsp_data", if_rsp_data, 32'h1111_2222);
        chk("f_dm_rsp", dm_rsp_valid, 0);
        chk("f_idle", busy, 0);
        tick();
        chk("f_pulse_end", if_rsp_valid, 0);
        chk("f_data_hold", if_rsp_data, 32'h1111_2222);

        // store with memory back-pressure
        dm_req_valid = 1'b1; dm_we = 1'b1; dm_addr = 64'h8000_1000;
        dm_wstrb = 8'h0F; dm_wdata = 64'hDEAD_BEEF; mem_req_ready = 1'b0;
        settle();
        chk("s_dm_ready", dm_req_ready, 1);
        tick();
        dm_req_valid = 1'b0; dm_we = 1'b0; dm_wdata = 64'hFFFF_FFFF_FFFF_FFFF; dm_wstrb = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("s_hold_valid", mem_req_valid, 1);
            chk("s_hold_we", mem_we, 1);
            chk("s_hold_addr", mem_addr, 64'h8000_1000);
            chk("s_hold_wstrb", mem_wstrb, 8'h0F);
            chk("s_hold_wdata", mem_wdata, 64'hDEAD_BEEF);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 64'h0123_4567_89AB_CDEF;
        tick();
        mem_rsp_valid = 1'b0;
        settle();
        chk("s_ack", dm_rsp_valid, 1);
        chk("s_ack_if", if_rsp_valid, 0);
        chk("s_ack_data", dm_rsp_data, 64'h0123_4567_89AB_CDEF);
        tick();
        chk("s_ack_once", dm_rsp_valid, 0);

        // round-robin from reset: IF, DM, IF, DM, IF, DM
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        if_req_valid = 1'b1; if_addr = 64'h100;
        dm_req_valid = 1'b1; dm_addr = 64'h208; dm_we = 1'b0; dm_wstrb = '0;
        mem_req_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            logic exp_dm;
            exp_dm = (t % 2) == 1;
            settle();
            chk("rr_if_ready", if_req_ready, !exp_dm);
            chk("rr_dm_ready", dm_req_ready, exp_dm);
            tick();
            chk("rr_addr", mem_addr, exp_dm ? 64'h208 : 64'h100);
            chk("rr_no_ready", {if_req_ready, dm_req_ready}, 0);
            tick();
            mem_rsp_valid = 1'b1; mem_rsp_data = 64'hAAAA_BBBB_CCCC_DDDD;
            tick();
            mem_rsp_valid = 1'b0;
            chk("rr_rsp", {if_rsp_valid, dm_rsp_valid}, exp_dm ? 2'b01 : 2'b10);
        end
        if_req_valid = 1'b0; dm_req_valid = 1'b0;
        chk("rr_if_data", if_rsp_data, 32'hCCCC_DDDD);
        tick();

        // stray memory responses in IDLE and ISSUE
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'h5555_5555_5555_5555;
        tick();
        mem_rsp_valid = 1'b0;
        chk("v_idle_rsp", {if_rsp_valid, dm_rsp_valid}, 0);
        chk("v_idle_busy", busy, 0);
        if_req_valid = 1'b1; if_addr = 64'h300; mem_req_ready = 1'b0;
        tick();
        if_req_valid = 1'b0; mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        chk("v_issue_rsp", {if_rsp_valid, dm_rsp_valid}, 0);
        chk("v_issue_hold", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 64'h0000_0000_1234_5678;
        tick();
        mem_rsp_valid = 1'b0;
        chk("v_rsp", if_rsp_valid, 1);
        chk("v_rsp_data", if_rsp_data, 32'h1234_5678);
        tick();

        // reset during WAIT, late response dropped
        dm_req_valid = 1'b1; dm_addr = 64'h400; mem_req_ready = 1'b1;
        tick();
        dm_req_valid = 1'b0;
        tick();
        mem_req_ready = 1'b0;
        chk("r_in_wait", {busy, mem_req_valid}, 2'b10);
        rst = 1'b0;
        settle();
        chk("r_busy", busy, 0);
        chk("r_mem_valid", mem_req_valid, 0);
        chk("r_mem_addr", mem_addr, 0);
        chk("r_rsp_data", {if_rsp_data, dm_rsp_data[31:0]}, 0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'h9999_8888_7777_6666;
        tick();
        mem_rsp_valid = 1'b0;
        chk("r_late_drop", {if_rsp_valid, dm_rsp_valid}, 0);
        chk("r_late_busy", busy, 0);
        if_req_valid = 1'b1; if_addr = 64'h8000_0000; mem_req_ready = 1'b1;
        settle();
        chk("r_next_ready", if_req_ready, 1);
        tick();
        if_req_valid = 1'b0;
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'hFEED_FACE_CAFE_F00D;
        tick();
        mem_rsp_valid = 1'b0;
        chk("r_next_rsp", if_rsp_valid, 1);
        chk("r_next_data", if_rsp_data, 32'hCAFE_F00D);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares the single memory port (`ram_top` side) between the instruction-fetch requester and the load/store data requester. It accepts one request at a time and issues it to memory, holding the address, write data and byte strobes stable until the memory accepts them. It waits for the memory response and returns it, registered, to the requester that owns the transaction. It sits between `if_top`/`ex_top` and memory, and is the step that lets the core move off an ideal single-cycle dual-port RAM.

## Interface
- `ADDR_W`, default 64: address width.
- `DATA_W`, default 64: memory data width; `DATA_W/8` strobes.
- `clk`  in  1  core clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `if_req_valid`  in  1  fetch request.
- `if_req_ready`  out  1  fetch request accepted this cycle.
- `if_addr`  in  ADDR_W  fetch address (4-byte aligned).
- `if_rsp_valid`  out  1  one-cycle pulse, fetch data valid.
- `if_rsp_data`  out  32  fetched instruction.
- `dm_req_valid`  in  1  data request.
- `dm_req_ready`  out  1  data request accepted this cycle.
- `dm_addr`  in  ADDR_W  data address.
- `dm_we`  in  1  1 = store, 0 = load.
- `dm_wstrb`  in  DATA_W/8  store byte enables.
- `dm_wdata`  in  DATA_W  store data.
- `dm_rsp_valid`  out  1  one-cycle pulse, load data valid or store acknowledged.
- `dm_rsp_data`  out  DATA_W  raw 64-bit load data; byte/half/word extraction stays in the load path.
- `mem_req_valid`  out  1  request to memory.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_addr`, `mem_we`, `mem_wstrb`, `mem_wdata`  out  ADDR_W/1/DATA_W/8/DATA_W  latched request fields.
- `mem_rsp_valid`  in  1  memory response or write ack.
- `mem_rsp_data`  in  DATA_W  memory read data.
- `busy`  out  1  state != IDLE.

## Operation
- FSM states:
  - IDLE: no transaction owned.
  - ISSUE: driving `mem_req_valid`.
  - WAIT: awaiting `mem_rsp_valid`.
- IDLE, no requests: remain in IDLE.
- IDLE, at least one request: arbitrate.
  - Winner's `*_req_ready` = 1 combinationally in the same cycle.
  - Latch addr/we/wstrb/wdata and owner bit.
  - Go to ISSUE.
  - The loser sees ready = 0 and must hold its request stable.
- Arbitration is 2-way round-robin on `last_grant`.
  - Only one requester: it wins.
  - Both requesting: the requester not equal to `last_grant` wins.
  - `last_grant` updates on every acceptance.
- Fetch requests are latched with `we` = 0 and `wstrb` = 0.
- ISSUE: `mem_req_valid` = 1, fields driven from latches. `mem_req_ready` = 1 → WAIT; otherwise hold.
- WAIT: on `mem_rsp_valid` = 1:
  - Register the response to the owner: `*_rsp_valid` = 1 for exactly the next cycle.
  - Go to IDLE on the same edge.
- Fetch data = `mem_rsp_data[63:32]` if latched `addr[2]` = 1, else `mem_rsp_data[31:0]`.
- Stores also wait for `mem_rsp_valid` (ack); `dm_rsp_data` is don't-care but is still loaded.
- `mem_rsp_valid` in IDLE or ISSUE is a protocol violation: ignored, no state change.
- `*_rsp_data` holds its last value between pulses.

## Timing
- Reset values:
  - All `*_ready`, `*_rsp_valid` and `mem_req_valid` = 0.
  - `*_rsp_data`, `mem_*` fields = 0.
  - State = IDLE, `busy` = 0.
  - `last_grant` = data, so fetch wins the first tie.
- Latency with `mem_req_ready` tied high and a 1-cycle memory:
  - Accept at cycle 0.
  - `mem_req_valid` at cycle 1.
  - `mem_rsp_valid` at cycle 2.
  - `*_rsp_valid` at cycle 3.
  - Next acceptance possible at cycle 3.
- Exactly one transaction outstanding; throughput at most one per 3 cycles.
- Reset asserted mid-transaction:
  - Immediate return to IDLE; `mem_req_valid` drops asynchronously.
  - A late `mem_rsp_valid` after reset release is dropped (arrives in IDLE).
- Simultaneous `if_req_valid` and `dm_req_valid` in IDLE: exactly one ready asserted, never both.

## Structure
- Add to `defines.v`:
  - State encodings `ARB_IDLE`/`ARB_ISSUE`/`ARB_WAIT` (2-bit).
  - `ARB_OWNER_IF`/`ARB_OWNER_DM`.
  - Width macros reuse `DATA_BUS`/`INST_ADDR_BUS`.
- One sub-module `rr_arb2`: combinational grant plus the `last_grant` flop, instantiated once.
- FSM, request latches and response registers live in `mem_port_arbiter`.

## Test plan
- Single fetch to 0x80000004, memory returns 0x1111_2222_3333_4444 one cycle after accept → `if_rsp_valid` pulses at cycle 3 with `if_rsp_data` = 0x11112222; `dm_rsp_valid` stays 0.
- Store to 0x80001000, `wstrb` = 0x0F, `wdata` = 0xDEADBEEF → `mem_we` = 1 with fields stable while `mem_req_ready` is held low 4 cycles; `dm_rsp_valid` pulses once after the ack.
- Both requesting continuously for 6 transactions after reset → grant order IF, DM, IF, DM, IF, DM; loser ready = 0 each time.
- `mem_rsp_valid` = 1 injected in IDLE and in ISSUE → no response pulse, state unchanged.
- `rst` pulled low during WAIT, then released; memory response arrives 2 cycles later → outputs zero during reset, response dropped, next request served normally.
